frequency_meter: RTL and testbench

//   Measures the frequency of an external square wave against the system clock.

---
 rtl/frequency_meter_pkg.sv | 16 +
 rtl/frequency_meter_edge_synchronizer.sv | 34 +++
 rtl/frequency_meter.sv | 122 ++++++++++++
 tb/tb_frequency_meter.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/frequency_meter_pkg.sv
// Shared types and helpers for the frequency meter: FSM state encoding and
// the gate-window length derived from the clock and gate rates.
package frequency_meter_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARM     = 2'd1,
    MEASURE = 2'd2
  } meter_state_t;

  // Number of system clocks in one gate window.
  function automatic int window_cycles(input int freq_in, input int gate_freq);
    return freq_in / gate_freq;
  endfunction

endpackage

// File: rtl/frequency_meter_edge_synchronizer.sv
// Brings the asynchronous input into the clock domain and flags rising edges.
// prev only follows the synchronized level while primed or tracking.
module edge_synchronizer #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clock_i,
  input  logic reset_n_i,
  input  logic signal_i,
  input  logic prime_i,
  input  logic track_i,
  output logic rise_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic                   level;

  assign level = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], signal_i};
      if (prime_i || track_i) begin
        prev_q <= level;
      end
    end
  end

  assign rise_o = level & ~prev_q;

endmodule

// File: rtl/frequency_meter.sv
// Counts rising edges of signal_i over back-to-back gate windows and
// publishes each window's (saturated) count with a one-cycle valid strobe.
module frequency_meter
  import frequency_meter_pkg::*;
#(
  parameter int WORD_LENGTH    = 16,
  parameter int FREQUENCY_IN   = 100000000,
  parameter int GATE_FREQUENCY = 1000,
  parameter int SYNC_STAGES    = 2
) (
  input  logic                   clock_i,
  input  logic                   reset_n_i,
  input  logic                   enable_i,
  input  logic                   signal_i,
  output logic [WORD_LENGTH-1:0] count_o,
  output logic                   valid_o,
  output logic                   overflow_o,
  output logic                   busy_o
);

  localparam int WINDOW = window_cycles(FREQUENCY_IN, GATE_FREQUENCY);
  localparam int WCNT_W = $clog2(WINDOW);
  localparam int ACNT_W = $clog2(SYNC_STAGES);
  localparam logic [WCNT_W-1:0]      WINDOW_LAST = WCNT_W'(WINDOW - 1);
  localparam logic [ACNT_W-1:0]      ARM_LAST    = ACNT_W'(SYNC_STAGES - 1);
  localparam logic [WORD_LENGTH-1:0] ECNT_MAX    = '1;

  meter_state_t           state_q, state_d;
  logic [WCNT_W-1:0]      wcnt_q;
  logic [ACNT_W-1:0]      acnt_q;
  logic [WORD_LENGTH-1:0] ecnt_q, ecnt_next;
  logic                   sticky_q, sticky_next;
  logic                   rise, prime, track, window_end;

  edge_synchronizer #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clock_i  (clock_i),
    .reset_n_i(reset_n_i),
    .signal_i (signal_i),
    .prime_i  (prime),
    .track_i  (track),
    .rise_o   (rise)
  );

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ARM lasts SYNC_STAGES cycles; prev is primed on its final cycle.
  always_comb begin
    state_d    = state_q;
    prime      = 1'b0;
    track      = 1'b0;
    window_end = 1'b0;
    case (state_q)
      IDLE: begin
        if (enable_i) state_d = ARM;
      end
      ARM: begin
        prime = (acnt_q == ARM_LAST);
        if (!enable_i)  state_d = IDLE;
        else if (prime) state_d = MEASURE;
      end
      MEASURE: begin
        track      = 1'b1;
        window_end = (wcnt_q == WINDOW_LAST);
        if (!enable_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // An edge arriving while the count is already all-ones marks the window as overflowed.
  always_comb begin
    ecnt_next   = ecnt_q;
    sticky_next = sticky_q;
    if (track && rise) begin
      if (ecnt_q == ECNT_MAX) sticky_next = 1'b1;
      else                    ecnt_next   = ecnt_q + WORD_LENGTH'(1);
    end
  end

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      acnt_q     <= '0;
      wcnt_q     <= '0;
      ecnt_q     <= '0;
      sticky_q   <= 1'b0;
      count_o    <= '0;
      overflow_o <= 1'b0;
      valid_o    <= 1'b0;
    end else begin
      valid_o <= 1'b0;
      if (state_q == ARM) acnt_q <= acnt_q + ACNT_W'(1);
      else                acnt_q <= '0;
      if (!track) begin
        wcnt_q   <= '0;
        ecnt_q   <= '0;
        sticky_q <= 1'b0;
      end else if (window_end) begin
        count_o    <= ecnt_next;
        overflow_o <= sticky_next;
        valid_o    <= 1'b1;
        wcnt_q     <= '0;
        ecnt_q     <= '0;
        sticky_q   <= 1'b0;
      end else begin
        wcnt_q   <= wcnt_q + WCNT_W'(1);
        ecnt_q   <= ecnt_next;
        sticky_q <= sticky_next;
      end
    end
  end

  assign busy_o = (state_q != IDLE);

endmodule

// File: tb/tb_frequency_meter.sv
// Directed bench for frequency_meter: a window-arithmetic model checked every
// cycle against an 8-bit and a 4-bit instance, plus hand-computed literals.
module tb_frequency_meter;

  localparam int FREQ_IN = 1000;
  localparam int GATE    = 10;
  localparam int WINDOW  = 100;
  localparam int SYNC    = 2;
  localparam int HIST    = 16384;

  logic       clock_i   = 1'b0;
  logic       reset_n_i = 1'b0;
  logic       enable_i  = 1'b0;
  logic       signal_i  = 1'b0;
  logic [7:0] count8;
  logic       valid8, ovf8, busy8;
  logic [3:0] count4;
  logic       valid4, ovf4, busy4;

  int tests = 0;
  int fails = 0;

  frequency_meter #(
    .WORD_LENGTH(8), .FREQUENCY_IN(FREQ_IN), .GATE_FREQUENCY(GATE), .SYNC_STAGES(SYNC)
  ) dut (
    .clock_i(clock_i), .reset_n_i(reset_n_i), .enable_i(enable_i), .signal_i(signal_i),
    .count_o(count8), .valid_o(valid8), .overflow_o(ovf8), .busy_o(busy8)
  );

  frequency_meter #(
    .WORD_LENGTH(4), .FREQUENCY_IN(FREQ_IN), .GATE_FREQUENCY(GATE), .SYNC_STAGES(SYNC)
  ) dut4 (
    .clock_i(clock_i), .reset_n_i(reset_n_i), .enable_i(enable_i), .signal_i(signal_i),
    .count_o(count4), .valid_o(valid4), .overflow_o(ovf4), .busy_o(busy4)
  );

  always #5 clock_i = ~clock_i;

  task automatic check_output(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  // Model: windows are located by arithmetic on the acceptance cycle of enable.
  int   m_n = 0, m_start = 0, m_edges = 0, m_c = 0, m_pos = 0;
  bit   m_active = 1'b0, m_valid = 1'b0, m_busy = 1'b0;
  bit   m_ovf8 = 1'b0, m_ovf4 = 1'b0;
  int   m_count8 = 0, m_count4 = 0;
  bit   samp [0:HIST-1];

  always @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      m_active = 1'b0; m_valid = 1'b0; m_busy = 1'b0; m_edges = 0;
      m_count8 = 0; m_count4 = 0; m_ovf8 = 1'b0; m_ovf4 = 1'b0;
    end else begin
      m_n++;
      samp[m_n] = signal_i;
      m_valid = 1'b0;
      m_c = m_n - 1;
      if (!m_active) begin
        if (enable_i) begin
          m_active = 1'b1;
          m_start  = m_n;
          m_edges  = 0;
        end
      end else begin
        if (m_c >= m_start + SYNC) begin
          m_pos = m_c - (m_start + SYNC);
          if (samp[m_c - SYNC + 1] && !samp[m_c - SYNC]) m_edges++;
          if (m_pos % WINDOW == WINDOW - 1) begin
            m_count8 = (m_edges > 255) ? 255 : m_edges;
            m_ovf8   = (m_edges > 255);
            m_count4 = (m_edges > 15) ? 15 : m_edges;
            m_ovf4   = (m_edges > 15);
            m_valid  = 1'b1;
            m_edges  = 0;
          end
        end
        if (!enable_i) begin
          m_active = 1'b0;
          m_edges  = 0;
        end
      end
      m_busy = m_active;
    end
  end

  always @(negedge clock_i) begin
    check_output("model count8", 32'(count8), 32'(m_count8));
    check_output("model valid8", 32'(valid8), 32'(m_valid));
    check_output("model ovf8",   32'(ovf8),   32'(m_ovf8));
    check_output("model busy8",  32'(busy8),  32'(m_busy));
    check_output("model count4", 32'(count4), 32'(m_count4));
    check_output("model valid4", 32'(valid4), 32'(m_valid));
    check_output("model ovf4",   32'(ovf4),   32'(m_ovf4));
    check_output("model busy4",  32'(busy4),  32'(m_busy));
  end

  // Stimulus waveform, indexed by negedges since enable was raised.
  int   jcnt        = 0;
  int   wave_period = 10;
  logic static_level = 1'b0;
  bit   extra_rise  = 1'b0;

  function automatic logic wave(input int j);
    if (wave_period == 0) return static_level;
    if (extra_rise && j == 100) return 1'b1;
    if (j < 1) return 1'b0;
    return ((j - 1) % wave_period) < (wave_period / 2);
  endfunction

  task automatic apply_stimulus(input int ncyc);
    repeat (ncyc) begin
      @(negedge clock_i);
      signal_i = wave(jcnt);
      jcnt++;
    end
  endtask

  task automatic start_enable();
    @(negedge clock_i);
    enable_i = 1'b1;
    jcnt     = 0;
    signal_i = wave(0);
    jcnt     = 1;
  endtask

  initial begin
    // Reset held while the input toggles.
    repeat (20) begin
      @(negedge clock_i);
      signal_i = ~signal_i;
    end
    check_output("reset count", 32'(count8), 32'd0);
    check_output("reset valid", 32'(valid8), 32'd0);
    check_output("reset ovf",   32'(ovf8),   32'd0);
    check_output("reset busy",  32'(busy8),  32'd0);
    @(negedge clock_i);
    reset_n_i = 1'b1;
    signal_i  = 1'b0;
    apply_stimulus(5);

    // Period-10 input: first publish 102 clocks after enable, then every 100.
    wave_period = 10;
    start_enable();
    apply_stimulus(102);
    check_output("first valid early", 32'(valid8), 32'd0);
    apply_stimulus(1);
    check_output("first valid",  32'(valid8), 32'd1);
    check_output("first count",  32'(count8), 32'd10);
    check_output("busy measure", 32'(busy8),  32'd1);
    apply_stimulus(100);
    check_output("second valid", 32'(valid8), 32'd1);
    check_output("second count", 32'(count8), 32'd10);

    // Abort at wcnt=50, then re-enable.
    apply_stimulus(50);
    enable_i = 1'b0;
    apply_stimulus(1);
    check_output("abort busy",  32'(busy8),  32'd0);
    check_output("abort valid", 32'(valid8), 32'd0);
    check_output("abort count", 32'(count8), 32'd10);
    apply_stimulus(10);
    start_enable();
    apply_stimulus(102);
    check_output("reenable early", 32'(valid8), 32'd0);
    apply_stimulus(1);
    check_output("reenable valid", 32'(valid8), 32'd1);
    check_output("reenable count", 32'(count8), 32'd10);
    enable_i = 1'b0;
    apply_stimulus(10);

    // Static-high input across enable: no false edge.
    wave_period  = 0;
    static_level = 1'b1;
    apply_stimulus(10);
    start_enable();
    apply_stimulus(103);
    check_output("static count", 32'(count8), 32'd0);
    check_output("static valid", 32'(valid8), 32'd1);
    check_output("static ovf",   32'(ovf8),   32'd0);
    apply_stimulus(100);
    check_output("static count2", 32'(count8), 32'd0);
    check_output("static valid2", 32'(valid8), 32'd1);
    enable_i = 1'b0;
    apply_stimulus(5);
    static_level = 1'b0;
    apply_stimulus(5);

    // Period 4 (25 edges) saturates the 4-bit instance; next window at period 10.
    wave_period = 4;
    start_enable();
    apply_stimulus(100);
    wave_period = 10;
    apply_stimulus(3);
    check_output("sat count4", 32'(count4), 32'd15);
    check_output("sat ovf4",   32'(ovf4),   32'd1);
    check_output("sat valid4", 32'(valid4), 32'd1);
    check_output("wide count8", 32'(count8), 32'd25);
    check_output("wide ovf8",   32'(ovf8),   32'd0);
    apply_stimulus(100);
    check_output("recover count4", 32'(count4), 32'd10);
    check_output("recover ovf4",   32'(ovf4),   32'd0);
    check_output("recover count8", 32'(count8), 32'd10);
    enable_i = 1'b0;
    apply_stimulus(5);

    // Extra rise on the last window cycle, then async reset mid-window.
    extra_rise = 1'b1;
    start_enable();
    apply_stimulus(103);
    check_output("edge at wcnt99", 32'(count8), 32'd11);
    apply_stimulus(40);
    check_output("count before reset", 32'(count8), 32'd11);
    #2;
    reset_n_i = 1'b0;
    #1;
    check_output("async count8", 32'(count8), 32'd0);
    check_output("async valid8", 32'(valid8), 32'd0);
    check_output("async ovf8",   32'(ovf8),   32'd0);
    check_output("async busy8",  32'(busy8),  32'd0);
    check_output("async count4", 32'(count4), 32'd0);
    check_output("async busy4",  32'(busy4),  32'd0);
    extra_rise = 1'b0;
    enable_i   = 1'b0;
    repeat (3) @(negedge clock_i);
    reset_n_i = 1'b1;
    apply_stimulus(5);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
